// File: rtl/rv32_defs.sv
// rv32_defs: shared RV32I opcodes, immediate-type encodings and decoded bundle types
package rv32_defs;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_B    = 3'd1,
    IMM_S    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_type_t;
  typedef struct packed {
    logic alu_src_imm;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic pc_rel;
  } ctrl_t;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [24:0] imm_field;
    imm_type_t   imm_type;
    ctrl_t       ctrl;
    logic        illegal;
  } bundle_t;
endpackage

// File: rtl/rv32_ctrl_dec.sv
// rv32_ctrl_dec: combinational opcode decoder producing immediate type, control bits and illegal flag
module rv32_ctrl_dec
  import rv32_defs::*;
(
  input  logic [6:0] opcode,
  output imm_type_t  imm_type,
  output ctrl_t      ctrl,
  output logic       illegal
);
  // unsupported opcodes fall through with every control bit left clear
  always_comb begin
    imm_type = IMM_NONE;
    ctrl = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_type = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_AUIPC: begin
        imm_type = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.pc_rel = 1'b1;
      end
      OP_JAL: begin
        imm_type = IMM_J;
        ctrl.reg_write = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.pc_rel = 1'b1;
      end
      OP_JALR: begin
        imm_type = IMM_I;
        ctrl.reg_write = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_BRANCH: begin
        imm_type = IMM_B;
        ctrl.branch = 1'b1;
        ctrl.pc_rel = 1'b1;
      end
      OP_LOAD: begin
        imm_type = IMM_I;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_STORE: begin
        imm_type = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_IMM: begin
        imm_type = IMM_I;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_OP: ctrl.reg_write = 1'b1;
      OP_FENCE: ;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with valid/ready handshake and flush; ID_SKID_EN adds a skid entry and a registered if_ready
module id_stage #(
  parameter int XLEN = rv32_defs::XLEN,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            funct7_b5,
  output logic [24:0]     imm_field,
  output logic [2:0]      imm_type,
  output logic            alu_src_imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            pc_rel,
  output logic            illegal
);
  import rv32_defs::*;
  imm_type_t dec_type;
  ctrl_t dec_ctrl;
  ctrl_t wb_ctrl;
  logic dec_illegal;
  bundle_t d;
  bundle_t q;
  logic [XLEN-1:0] q_pc;
  rv32_ctrl_dec u_dec (
    .opcode(if_instr[6:0]),
    .imm_type(dec_type),
    .ctrl(dec_ctrl),
    .illegal(dec_illegal)
  );
  // writes to x0 are architecturally dropped, so never request one
  always_comb begin
    wb_ctrl = dec_ctrl;
    wb_ctrl.reg_write = dec_ctrl.reg_write & (|if_instr[11:7]);
  end
  assign d = '{
    rs1: if_instr[19:15],
    rs2: if_instr[24:20],
    rd: if_instr[11:7],
    funct3: if_instr[14:12],
    funct7_b5: if_instr[30],
    imm_field: if_instr[31:7],
    imm_type: dec_type,
    ctrl: wb_ctrl,
    illegal: dec_illegal
  };
`ifdef ID_SKID_EN
  bundle_t s;
  logic [XLEN-1:0] s_pc;
  logic s_valid;
  logic main_free;
  assign main_free = !ex_valid | ex_ready;
  assign if_ready = !s_valid;
  // main register refills from the skid entry first; a stalled accept parks in the skid entry
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      s_valid <= 1'b0;
      q <= '0;
      q.imm_type <= IMM_NONE;
      q_pc <= RST_PC;
    end else if (flush) begin
      ex_valid <= 1'b0;
      s_valid <= 1'b0;
      q.ctrl <= '0;
      q.illegal <= 1'b0;
    end else if (main_free) begin
      ex_valid <= s_valid | if_valid;
      if (s_valid) begin
        q <= s;
        q_pc <= s_pc;
        s_valid <= 1'b0;
      end else if (if_valid) begin
        q <= d;
        q_pc <= if_pc;
      end
    end else if (if_valid & !s_valid) begin
      s <= d;
      s_pc <= if_pc;
      s_valid <= 1'b1;
    end
  end
`else
  assign if_ready = !ex_valid | ex_ready;
  // single pipeline register, loaded whenever the downstream slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      q <= '0;
      q.imm_type <= IMM_NONE;
      q_pc <= RST_PC;
    end else if (flush) begin
      ex_valid <= 1'b0;
      q.ctrl <= '0;
      q.illegal <= 1'b0;
    end else if (if_ready) begin
      ex_valid <= if_valid;
      if (if_valid) begin
        q <= d;
        q_pc <= if_pc;
      end
    end
  end
`endif
  assign ex_pc = q_pc;
  assign rs1 = q.rs1;
  assign rs2 = q.rs2;
  assign rd = q.rd;
  assign funct3 = q.funct3;
  assign funct7_b5 = q.funct7_b5;
  assign imm_field = q.imm_field;
  assign imm_type = q.imm_type;
  assign alu_src_imm = q.ctrl.alu_src_imm;
  assign reg_write = q.ctrl.reg_write;
  assign mem_read = q.ctrl.mem_read;
  assign mem_write = q.ctrl.mem_write;
  assign branch = q.ctrl.branch;
  assign jump = q.ctrl.jump;
  assign pc_rel = q.ctrl.pc_rel;
  assign illegal = q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage with a table-driven decode reference model
module tb_id_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_valid = 1'b0;
  logic if_ready;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic flush = 1'b0;
  logic ex_valid;
  logic ex_ready = 1'b1;
  logic [31:0] ex_pc;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic funct7_b5;
  logic [24:0] imm_field;
  logic [2:0] imm_type;
  logic alu_src_imm, reg_write, mem_read, mem_write, branch, jump, pc_rel, illegal;
  id_stage #(.XLEN(32), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .funct7_b5(funct7_b5), .imm_field(imm_field),
    .imm_type(imm_type), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .pc_rel(pc_rel), .illegal(illegal)
  );
  always #5 clk = ~clk;
  // control vector order: {alu_src_imm, reg_write, mem_read, mem_write, branch, jump, pc_rel}
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] ty;
    logic [6:0] c;
  } row_t;
  row_t tbl [10] = '{
    {7'b0110111, 3'd3, 7'b1100000},
    {7'b0010111, 3'd3, 7'b1100001},
    {7'b1101111, 3'd4, 7'b0100011},
    {7'b1100111, 3'd0, 7'b1100010},
    {7'b1100011, 3'd1, 7'b0000101},
    {7'b0000011, 3'd0, 7'b1110000},
    {7'b0100011, 3'd2, 7'b1001000},
    {7'b0010011, 3'd0, 7'b1100000},
    {7'b0110011, 3'd7, 7'b0100000},
    {7'b0001111, 3'd7, 7'b0000000}
  };
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0] ty;
    logic [6:0] c;
    logic ill;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  logic rst_prev = 1'b0;
  logic flush_prev = 1'b0;
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.ty = 3'd7;
    e.c = '0;
    e.ill = 1'b1;
    foreach (tbl[i]) if (tbl[i].op == instr[6:0]) begin
      e.ty = tbl[i].ty;
      e.c = tbl[i].c;
      e.ill = 1'b0;
    end
    if (instr[11:7] == 5'd0) e.c[5] = 1'b0;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [6:0] ctrl_out();
    return {alu_src_imm, reg_write, mem_read, mem_write, branch, jump, pc_rel};
  endfunction
  // monitor: compare presented bundle with scoreboard head, then account for this cycle's transfers
  always begin
    @(negedge clk);
    #2;
    if (rst_prev) begin
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_imm_type", 32'(imm_type), 7);
      chk("rst_pc", ex_pc, RST_PC);
      chk("rst_ctrl", {ctrl_out(), illegal}, 0);
      chk("rst_fields", {rs1, rs2, rd, funct3, funct7_b5}, 0);
      chk("rst_imm_field", 32'(imm_field), 0);
    end else begin
      chk("valid", 32'(ex_valid), 32'(sb.size() != 0));
      if (ex_valid && sb.size() != 0) begin
        chk("pc", ex_pc, sb[0].pc);
        chk("regs", {rs1, rs2, rd}, {sb[0].instr[19:15], sb[0].instr[24:20], sb[0].instr[11:7]});
        chk("funct", {funct3, funct7_b5}, {sb[0].instr[14:12], sb[0].instr[30]});
        chk("imm_field", 32'(imm_field), 32'(sb[0].instr[31:7]));
        chk("imm_type", 32'(imm_type), 32'(sb[0].ty));
        chk("ctrl", 32'(ctrl_out()), 32'(sb[0].c));
        chk("illegal", 32'(illegal), 32'(sb[0].ill));
      end
      if (flush_prev) chk("flush_ctrl", 32'(ctrl_out()), 0);
    end
    if (!rst) begin
`ifdef ID_SKID_EN
      chk("if_ready", 32'(if_ready), 32'(sb.size() < 2));
`else
      chk("if_ready", 32'(if_ready), 32'(!ex_valid || ex_ready));
`endif
    end
    rst_prev = rst;
    flush_prev = flush;
    if (rst || flush) sb.delete();
    else begin
      if (ex_valid && ex_ready && sb.size() != 0) void'(sb.pop_front());
      if (if_valid && if_ready) sb.push_back(model(if_instr, if_pc));
    end
  end
  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    @(negedge clk);
    if_valid = v;
    if_instr = ins;
    if_pc = if_pc + 32'd4;
    ex_ready = rdy;
    flush = fl;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    ins[6:0] = ($urandom_range(0, 11) == 11) ? 7'($urandom) : tbl[$urandom_range(0, 9)].op;
    if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction
  initial begin
    if_valid = 1'b1;
    if_instr = 32'h00500093;
    if_pc = 32'h0000_00fc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    if_valid = 1'b0;
    drive(1, 32'h00500093, 1, 0);
    drive(1, 32'h0020A623, 1, 0);
    drive(1, 32'h0080A103, 1, 0);
    repeat (3) drive(1, 32'h000000EF, 0, 0);
    drive(1, 32'h000000EF, 1, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);
    drive(1, 32'h00208463, 0, 0);
    drive(1, 32'h00500093, 0, 1);
    drive(0, 32'h0, 1, 0);
    drive(1, 32'h00000000, 1, 0);
    drive(1, 32'h00000013, 1, 0);
    drive(0, 32'h0, 1, 0);
    repeat (400) drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    repeat (4) drive(0, 32'h0, 1, 0);
    @(negedge clk);
    #3;
    chk("drain_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
